// File: rtl/usb_cmd_pkg.sv
// Shared constants for the USB command-frame parser: FSM encodings,
// opcodes, error codes and the running-checksum helper.
package usb_cmd_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_CMD  = 3'd1;
  localparam state_t ST_ADDR = 3'd2;
  localparam state_t ST_LEN  = 3'd3;
  localparam state_t ST_DATA = 3'd4;
  localparam state_t ST_CSUM = 3'd5;
  localparam state_t ST_DONE = 3'd6;

  localparam logic [7:0] OP_WRITE = 8'h01;

  typedef logic [1:0] err_code_t;

  localparam err_code_t ERR_CSUM = 2'd0;
  localparam err_code_t ERR_LEN  = 2'd1;
  localparam err_code_t ERR_OP   = 2'd2;
  localparam err_code_t ERR_TMO  = 2'd3;

  // Checksum is a plain 16-bit wrapping sum.
  function automatic logic [15:0] csum_add(input logic [15:0] acc, input logic [15:0] word);
    return acc + word;
  endfunction

endpackage

// File: rtl/usb_cmd_timeout.sv
// Mid-frame idle watchdog: reloaded on every accepted word, counts down
// while a frame is open and flags expiry at terminal count.
module usb_cmd_timeout #(
  parameter int TIMEOUT = 1023
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic run_i,
  input  logic clear_i,
  output logic expire_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = CW'(TIMEOUT);
    end else if (run_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = run_i && (cnt_q == '0);

endmodule

// File: rtl/usb_cmd_parser.sv
// Parses SYNC/CMD/ADDR/LEN/payload/CSUM frames from the USB receive stream,
// streams payload into register writes and pulses done or err per frame.
//
// state | meaning
// IDLE  | hunting for SYNC_WORD, other words discarded
// CMD   | expecting command word (opcode in upper byte)
// ADDR  | expecting start address
// LEN   | expecting payload length
// DATA  | each word becomes one write, address auto-increments
// CSUM  | expecting checksum of CMD..last payload word
// DONE  | one-cycle good-frame pulse, input stalled
module usb_cmd_parser
  import usb_cmd_pkg::*;
#(
  parameter logic [15:0] SYNC_WORD = 16'hA55A,
  parameter int          ADDR_W    = 16,
  parameter int          MAX_LEN   = 256,
  parameter int          TIMEOUT   = 1023
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [15:0]       s_data_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [15:0]       wr_data_o,
  output logic              busy_o,
  output logic              frame_done_o,
  output logic              frame_err_o,
  output logic [1:0]        err_code_o
);

  localparam int          CNT_W     = $clog2(MAX_LEN + 1);
  localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);

  state_t            state_q, state_d;
  logic [15:0]       csum_q, csum_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              s_ready_q, s_ready_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [15:0]       wr_data_q, wr_data_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  err_code_t         err_code_q, err_code_d;

  logic beat;
  logic tmo_run;
  logic tmo_expire;

  assign beat    = s_valid_i && s_ready_q;
  assign tmo_run = (state_q != ST_IDLE) && (state_q != ST_DONE);

  usb_cmd_timeout #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .run_i   (tmo_run),
    .clear_i (beat),
    .expire_o(tmo_expire)
  );

  always_comb begin
    state_d    = state_q;
    csum_d     = csum_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    err_code_d = ERR_CSUM;

    case (state_q)
      ST_IDLE: begin
        if (beat && (s_data_i == SYNC_WORD)) begin
          state_d = ST_CMD;
          csum_d  = '0;
        end
      end
      ST_CMD: begin
        if (beat) begin
          csum_d = csum_add(csum_q, s_data_i);
          if (s_data_i[15:8] != OP_WRITE) begin
            state_d    = ST_IDLE;
            err_d      = 1'b1;
            err_code_d = ERR_OP;
          end else begin
            state_d = ST_ADDR;
          end
        end
      end
      ST_ADDR: begin
        if (beat) begin
          addr_d  = ADDR_W'(s_data_i);
          csum_d  = csum_add(csum_q, s_data_i);
          state_d = ST_LEN;
        end
      end
      ST_LEN: begin
        if (beat) begin
          if ((s_data_i == 16'h0000) || (s_data_i > MAX_LEN_W)) begin
            state_d    = ST_IDLE;
            err_d      = 1'b1;
            err_code_d = ERR_LEN;
          end else begin
            cnt_d   = CNT_W'(s_data_i);
            csum_d  = csum_add(csum_q, s_data_i);
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (beat) begin
          csum_d    = csum_add(csum_q, s_data_i);
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = s_data_i;
          addr_d    = addr_q + ADDR_W'(1);
          cnt_d     = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = ST_CSUM;
          end
        end
      end
      ST_CSUM: begin
        if (beat) begin
          if (s_data_i == csum_q) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d    = ST_IDLE;
            err_d      = 1'b1;
            err_code_d = ERR_CSUM;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A word accepted on the expiry cycle keeps the frame alive.
    if (tmo_expire && !beat) begin
      state_d    = ST_IDLE;
      err_d      = 1'b1;
      err_code_d = ERR_TMO;
    end

    s_ready_d = (state_d != ST_DONE);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      csum_q     <= '0;
      addr_q     <= '0;
      cnt_q      <= '0;
      s_ready_q  <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_CSUM;
    end else begin
      state_q    <= state_d;
      csum_q     <= csum_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      s_ready_q  <= s_ready_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  assign s_ready_o    = s_ready_q;
  assign wr_en_o      = wr_en_q;
  assign wr_addr_o    = wr_addr_q;
  assign wr_data_o    = wr_data_q;
  assign busy_o       = (state_q != ST_IDLE);
  assign frame_done_o = done_q;
  assign frame_err_o  = err_q;
  assign err_code_o   = err_code_q;

endmodule

// File: tb/tb_usb_cmd_parser.sv
// Bench for usb_cmd_parser: directed per-cycle vector table, hand-written
// timeout/reset sequences, and random streams against a frame-level model.
module tb_usb_cmd_parser;

  localparam logic [15:0] SYNC = 16'hA55A;

  logic        clk_i;
  logic        reset_i;
  logic [15:0] s_data_i;
  logic        s_valid_i;
  logic        s_ready_o;
  logic        wr_en_o;
  logic [15:0] wr_addr_o;
  logic [15:0] wr_data_o;
  logic        busy_o;
  logic        frame_done_o;
  logic        frame_err_o;
  logic [1:0]  err_code_o;

  int vectors     = 0;
  int miscompares = 0;

  usb_cmd_parser dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .s_data_i    (s_data_i),
    .s_valid_i   (s_valid_i),
    .s_ready_o   (s_ready_o),
    .wr_en_o     (wr_en_o),
    .wr_addr_o   (wr_addr_o),
    .wr_data_o   (wr_data_o),
    .busy_o      (busy_o),
    .frame_done_o(frame_done_o),
    .frame_err_o (frame_err_o),
    .err_code_o  (err_code_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  typedef struct {
    logic        rst;
    logic        v;
    logic [15:0] d;
    logic        en;
    logic [15:0] a;
    logic [15:0] wd;
    logic        done;
    logic        err;
    logic [1:0]  code;
    logic        rdy;
    logic        busy;
  } vec_t;

  typedef struct packed {
    logic [1:0]  kind;  // 0 write, 1 done, 2 err
    logic [15:0] a;
    logic [15:0] d;
  } ev_t;

  vec_t        tbl[$];
  ev_t         exp_q[$];
  ev_t         obs_q[$];
  logic [15:0] stream[$];
  bit          mon_en  = 1'b0;
  int          both_hi = 0;

  function automatic vec_t mk(logic rst, logic v, logic [15:0] d, logic en, logic [15:0] a,
                              logic [15:0] wd, logic done, logic err, logic [1:0] code,
                              logic rdy, logic busy);
    vec_t t;
    t.rst = rst; t.v = v; t.d = d; t.en = en; t.a = a; t.wd = wd;
    t.done = done; t.err = err; t.code = code; t.rdy = rdy; t.busy = busy;
    return t;
  endfunction

  // Accepted word inside a frame, no visible output.
  function automatic vec_t B(logic [15:0] d);
    return mk(0, 1, d, 0, 0, 0, 0, 0, 0, 1, 1);
  endfunction
  // Word discarded while hunting.
  function automatic vec_t H(logic [15:0] d);
    return mk(0, 1, d, 0, 0, 0, 0, 0, 0, 1, 0);
  endfunction
  // Payload word producing a write.
  function automatic vec_t W(logic [15:0] d, logic [15:0] a);
    return mk(0, 1, d, 1, a, d, 0, 0, 0, 1, 1);
  endfunction
  // Checksum word completing a good frame.
  function automatic vec_t D(logic [15:0] d);
    return mk(0, 1, d, 0, 0, 0, 1, 0, 0, 0, 1);
  endfunction
  // Word that aborts the frame with an error.
  function automatic vec_t E(logic [15:0] d, logic [1:0] code);
    return mk(0, 1, d, 0, 0, 0, 0, 1, code, 1, 0);
  endfunction
  function automatic vec_t I();
    return mk(0, 0, 16'h0, 0, 0, 0, 0, 0, 0, 1, 0);
  endfunction
  function automatic vec_t Q();
    return mk(0, 0, 16'h0, 0, 0, 0, 0, 0, 0, 1, 1);
  endfunction
  function automatic vec_t R(logic v, logic [15:0] d);
    return mk(1, v, d, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic apply(input vec_t t, input string name);
    logic [63:0] act, req;
    @(negedge clk_i);
    reset_i   = t.rst;
    s_valid_i = t.v;
    s_data_i  = t.d;
    @(posedge clk_i);
    #1;
    act = {25'd0, wr_en_o, frame_done_o, frame_err_o, s_ready_o, busy_o,
           frame_err_o ? err_code_o : 2'b00,
           wr_en_o ? wr_addr_o : 16'h0, wr_en_o ? wr_data_o : 16'h0};
    req = {25'd0, t.en, t.done, t.err, t.rdy, t.busy,
           t.err ? t.code : 2'b00,
           t.en ? t.a : 16'h0, t.en ? t.wd : 16'h0};
    check(name, act, req);
  endtask

  always @(posedge clk_i) begin
    #1;
    if (frame_done_o && frame_err_o) both_hi++;
    if (mon_en) begin
      if (wr_en_o)      obs_q.push_back({2'd0, wr_addr_o, wr_data_o});
      if (frame_done_o) obs_q.push_back({2'd1, 32'h0});
      if (frame_err_o)  obs_q.push_back({2'd2, 16'h0, 14'h0, err_code_o});
    end
  end

  task automatic push_err(input logic [1:0] code);
    exp_q.push_back({2'd2, 16'h0, 14'h0, code});
  endtask

  // Frame-level reference: walks the word list and lists expected writes and results.
  task automatic model_stream();
    int          i, n, len;
    logic [15:0] cmd, addr, sum;
    n = stream.size();
    i = 0;
    while (i < n) begin
      if (stream[i] != SYNC) begin
        i++;
        continue;
      end
      if (n - i < 2) begin push_err(2'd3); break; end
      cmd = stream[i+1];
      if (cmd[15:8] != 8'h01) begin
        push_err(2'd2);
        i += 2;
        continue;
      end
      if (n - i < 4) begin push_err(2'd3); break; end
      addr = stream[i+2];
      len  = int'(stream[i+3]);
      i += 4;
      if (len == 0 || len > 256) begin
        push_err(2'd1);
        continue;
      end
      sum = cmd + addr + 16'(len);
      for (int k = 0; k < len && i + k < n; k++) begin
        exp_q.push_back({2'd0, 16'(addr + 16'(k)), stream[i+k]});
        sum = sum + stream[i+k];
      end
      if (n - i < len + 1) begin push_err(2'd3); break; end
      if (stream[i+len] == sum) exp_q.push_back({2'd1, 32'h0});
      else                      push_err(2'd0);
      i += len + 1;
    end
  endtask

  task automatic gen_stream(input int frames, input bit want_max);
    int          kind, len, cut;
    logic [15:0] cmd, addr, sum, w;
    bit          need_max;
    need_max = want_max;
    for (int f = 0; f < frames; f++) begin
      kind = int'($urandom_range(0, 9));
      addr = 16'($urandom);
      cmd  = {8'h01, 8'($urandom)};
      case (kind)
        0: repeat ($urandom_range(1, 3)) stream.push_back(16'($urandom));
        1: begin
          stream.push_back(SYNC);
          stream.push_back({8'($urandom_range(2, 255)), 8'($urandom)});
        end
        2: begin
          stream.push_back(SYNC);
          stream.push_back(cmd);
          stream.push_back(addr);
          stream.push_back(($urandom_range(0, 1) == 0) ? 16'h0000 : 16'($urandom_range(257, 65535)));
        end
        default: begin
          if (need_max || $urandom_range(0, 15) == 0) len = 256;
          else                                        len = int'($urandom_range(1, 6));
          need_max = 1'b0;
          sum = cmd + addr + 16'(len);
          stream.push_back(SYNC);
          stream.push_back(cmd);
          stream.push_back(addr);
          stream.push_back(16'(len));
          for (int k = 0; k < len; k++) begin
            w = ($urandom_range(0, 7) == 0) ? SYNC : 16'($urandom);
            stream.push_back(w);
            sum = sum + w;
          end
          if (kind == 3) stream.push_back(sum + 16'($urandom_range(1, 65535)));
          else           stream.push_back(sum);
        end
      endcase
    end
    if ($urandom_range(0, 1) == 1) begin
      cut = int'($urandom_range(1, 3));
      repeat (cut) if (stream.size() > 0) void'(stream.pop_back());
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(negedge clk_i);
      s_valid_i = 1'b0;
      s_data_i  = 16'($urandom);
    end
  endtask

  task automatic drive_word(input logic [15:0] w);
    int tries;
    tries = 0;
    @(negedge clk_i);
    s_valid_i = 1'b1;
    s_data_i  = w;
    while (!s_ready_o && tries < 8) begin
      @(negedge clk_i);
      tries++;
    end
    if (!s_ready_o) begin
      vectors++;
      miscompares++;
      $display("FAIL ready_stall: got s_ready=0 for %0d cycles, expected 1", tries);
    end
    @(posedge clk_i);
  endtask

  task automatic run_round(input int frames, input bit want_max, input string tag);
    stream.delete();
    exp_q.delete();
    obs_q.delete();
    gen_stream(frames, want_max);
    model_stream();
    mon_en = 1'b1;
    foreach (stream[k]) begin
      if ($urandom_range(0, 3) == 0) idle_cycles(int'($urandom_range(1, 3)));
      drive_word(stream[k]);
    end
    idle_cycles(1100);  // long enough for a trailing partial frame to time out
    mon_en = 1'b0;
    check({tag, "_event_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++)
      check($sformatf("%s_event%0d", tag, k), 64'(obs_q[k]), 64'(exp_q[k]));
  endtask

  initial begin
    int n;
    reset_i   = 1'b1;
    s_valid_i = 1'b0;
    s_data_i  = 16'h0;

    // reset behaviour and first cycle after release
    tbl.push_back(R(0, 16'h0));
    tbl.push_back(R(1, SYNC));
    tbl.push_back(I());
    // good frame, writes on consecutive cycles
    tbl.push_back(B(SYNC));          tbl.push_back(B(16'h0100));
    tbl.push_back(B(16'h0010));      tbl.push_back(B(16'h0003));
    tbl.push_back(W(16'h1111, 16'h0010));
    tbl.push_back(W(16'h2222, 16'h0011));
    tbl.push_back(W(16'h3333, 16'h0012));
    tbl.push_back(D(16'h6779));
    tbl.push_back(I());
    // same frame, bad checksum: writes still happen
    tbl.push_back(B(SYNC));          tbl.push_back(B(16'h0100));
    tbl.push_back(B(16'h0010));      tbl.push_back(B(16'h0003));
    tbl.push_back(W(16'h1111, 16'h0010));
    tbl.push_back(W(16'h2222, 16'h0011));
    tbl.push_back(W(16'h3333, 16'h0012));
    tbl.push_back(E(16'h0000, 2'd0));
    tbl.push_back(I());
    // garbage then address wrap
    tbl.push_back(H(16'h1234));      tbl.push_back(H(16'h5678));
    tbl.push_back(B(SYNC));          tbl.push_back(B(16'h0100));
    tbl.push_back(B(16'hFFFF));      tbl.push_back(B(16'h0002));
    tbl.push_back(W(16'hAAAA, 16'hFFFF));
    tbl.push_back(W(16'hBBBB, 16'h0000));
    tbl.push_back(D(16'h6766));
    tbl.push_back(I());
    // length 0 and length MAX_LEN+1, next word hunted as SYNC
    tbl.push_back(B(SYNC));          tbl.push_back(B(16'h0100));
    tbl.push_back(B(16'h0000));      tbl.push_back(E(16'h0000, 2'd1));
    tbl.push_back(B(SYNC));          tbl.push_back(B(16'h0100));
    tbl.push_back(B(16'h0000));      tbl.push_back(E(16'h0101, 2'd1));
    tbl.push_back(I());
    // bad opcode
    tbl.push_back(B(SYNC));          tbl.push_back(E(16'h0200, 2'd2));
    tbl.push_back(I());
    // SYNC inside payload is data; word offered during DONE is stalled
    tbl.push_back(B(SYNC));          tbl.push_back(B(16'h0100));
    tbl.push_back(B(16'h0040));      tbl.push_back(B(16'h0002));
    tbl.push_back(W(SYNC, 16'h0040));
    tbl.push_back(W(SYNC, 16'h0041));
    tbl.push_back(D(16'h4BF6));
    tbl.push_back(mk(0, 1, SYNC, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(B(SYNC));          tbl.push_back(E(16'h0300, 2'd2));
    tbl.push_back(I());

    for (int k = 0; k < tbl.size(); k++) apply(tbl[k], $sformatf("dir%0d", k));

    // idle timeout: error appears after 1023 idle cycles plus the expiry cycle
    apply(B(SYNC), "tmo_sync");
    apply(B(16'h0100), "tmo_cmd");
    n = 0;
    do begin
      @(negedge clk_i);
      s_valid_i = 1'b0;
      @(posedge clk_i);
      #1;
      n++;
    end while (!frame_err_o && n < 1100);
    check("tmo_latency", 64'(n), 64'd1024);
    check("tmo_code", 64'(err_code_o), 64'd3);
    check("tmo_busy", 64'(busy_o), 64'd0);
    apply(I(), "tmo_after");

    // word arriving on the expiry cycle wins
    apply(B(SYNC), "tmo2_sync");
    apply(B(16'h0100), "tmo2_cmd");
    for (int k = 0; k < 1023; k++) apply(Q(), "tmo2_wait");
    apply(B(16'h0010), "tmo2_beat_on_expiry");
    apply(B(16'h0001), "tmo2_len");
    apply(W(16'h5555, 16'h0010), "tmo2_data");
    apply(D(16'h5666), "tmo2_csum");
    apply(I(), "tmo2_idle");

    // reset during DATA: no further writes, no pulse
    apply(B(SYNC), "rst_sync");
    apply(B(16'h0100), "rst_cmd");
    apply(B(16'h0020), "rst_addr");
    apply(B(16'h0004), "rst_len");
    apply(W(16'h0001, 16'h0020), "rst_d0");
    apply(W(16'h0002, 16'h0021), "rst_d1");
    apply(R(1, 16'h0003), "rst_assert");
    apply(R(1, 16'h0003), "rst_hold");
    apply(I(), "rst_release");
    apply(H(16'h0003), "rst_hunt0");
    apply(H(16'h0004), "rst_hunt1");
    apply(I(), "rst_idle");

    run_round(30, 1'b1, "rnd0");
    run_round(30, 1'b0, "rnd1");

    check("done_err_exclusive", 64'(both_hi), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
